ysyx_25020047_data_sram: RTL and testbench
==========================================

// Module: ysyx_25020047_data_sram
// PURPOSE
//   Memory-side responder for the LSU data port: accepts one read or write request at a time,
//   waits a programmable latency, performs the access on pmem via the pmem_read/pmem_write DPI
//   calls, returns a response. Sits between LSU and the simulated physical memory; models SRAM latency.
// PARAMETERS
//   LATENCY   1            cycles from request acceptance edge to resp_valid assertion (>=1)
//   PMEM_BASE 32'h8000_0000 lowest legal byte address
//   PMEM_SIZE 32'h0800_0000 legal window size in bytes
// PORTS
//   clk         in   1   clock; all state changes on rising edge
//   rst_n       in   1   asynchronous, active-low reset
//   req_valid   in   1   LSU presents a request
//   req_ready   out  1   responder can accept a request
//   req_wen     in   1   1 = write, 0 = read
//   req_addr    in   32  byte address; bits [1:0] ignored for access (word aligned)
//   req_wdata   in   32  write data, already shifted into byte lanes by LSU
//   req_wmask   in   4   byte-lane write enables (bit i -> wdata[8i+7:8i])
//   resp_valid  out  1   response available
//   resp_ready  in   1   LSU consumes response
//   resp_rdata  out  32  full aligned word for reads; 0 for writes
//   resp_err    out  1   address outside [PMEM_BASE, PMEM_BASE+PMEM_SIZE)
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
//   FSM states: IDLE, WAIT, RESP.
//   - IDLE: req_ready=1. req_valid&req_ready at edge T0 -> latch wen/addr/wdata/wmask;
//     LATENCY==1 -> perform access at T0, go RESP; else counter=LATENCY-2, go WAIT.
//   - WAIT: req_ready=0. counter!=0 -> decrement. counter==0 -> perform access at this edge, go RESP.
//   - RESP: resp_valid=1, rdata/err stable. resp_valid&resp_ready at edge -> IDLE, resp_valid=0 next cycle.
//     No new request accepted in same cycle as response handshake (req_ready=0 in RESP).
//   Net: resp_valid rises exactly LATENCY cycles after acceptance edge; 1 outstanding max.
//   Access (single edge, exactly once per request):
//   - read, in range: resp_rdata = pmem_read({addr[31:2],2'b00}); resp_err=0. Byte/half
//     extraction and sign/zero extension are the LSU's job.
//   - write, in range: pmem_write({addr[31:2],2'b00}, wdata, {28'b0,wmask}); resp_rdata=0.
//     wmask==0 -> no pmem call, normal response.
//   - out of range (either direction): no DPI call, resp_rdata=0, resp_err=1.
//   Range check: addr>=PMEM_BASE && (addr-PMEM_BASE)<PMEM_SIZE; unsigned 32-bit, no wrap past 2^32.
//   Inputs ignored outside IDLE; changes to req_* after acceptance have no effect.
//   resp_ready held high before resp_valid: harmless, consumed on first RESP cycle.
//   Reset mid-operation: in WAIT, access not yet done -> aborted, no pmem write; in RESP,
//   response dropped. Write already performed is not rolled back.
//   No combinational path from req_* to resp_*; req_ready depends on state only.
// STRUCTURE
//   Shared header ysyx_25020047_defines.vh: FSM state encodings (2 bits), PMEM_BASE/PMEM_SIZE
//   defaults, DPI import declarations for pmem_read/pmem_write (shared with LSU and IFU).
//   One sub-module: ysyx_25020047_lat_cnt (load value, decrement, zero flag); FSM, request
//   latch and DPI calls stay in this module.
// TESTING
//   1 LATENCY=1, write 0x8000_0000 wdata=0xDEADBEEF wmask=4'hF, then read -> rdata=0xDEADBEEF,
//     resp_valid 1 cycle after each acceptance, resp_err=0.
//   2 LATENCY=3, sb-style write addr 0x8000_0003 wdata=0xAB00_0000 wmask=4'h8 over 0x11223344
//     -> read 0x8000_0000 returns 0xAB223344; resp_valid exactly 3 cycles after acceptance.
//   3 resp_ready held low 5 cycles in RESP -> resp_valid/rdata stable, req_ready=0 throughout;
//     req_valid pulses ignored; after handshake req_ready=1 next cycle.
//   4 read 0x7FFF_FFFC and 0x8800_0000 -> resp_err=1, rdata=0, no DPI call (DPI call counter unchanged).
//   5 LATENCY=4, write accepted, rst_n low 2 cycles into WAIT -> outputs at reset values
//     asynchronously; subsequent read of that word returns old value.
//   6 write wmask=4'h0 to 0x8000_0010 holding 0x55AA55AA -> normal response, word unchanged.

Source files
------------

// File: rtl/ysyx_25020047_data_sram_pkg.sv
// rtl/ysyx_25020047_data_sram_pkg.sv - shared types, defaults and helpers for the data SRAM responder
package ysyx_25020047_data_sram_pkg;

    // Responder FSM state encoding (2 bits)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } sram_state_e;

    localparam logic [31:0] PMEM_BASE_DEF = 32'h8000_0000;
    localparam logic [31:0] PMEM_SIZE_DEF = 32'h0800_0000;

    // Wide enough for any practical latency setting
    localparam int CNT_W = 16;

    // Unsigned window check; the offset form avoids wrapping past 2^32
    function automatic logic in_pmem(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && (off < size);
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_25020047_data_sram_if.sv
// rtl/ysyx_25020047_data_sram_if.sv - LSU data port request/response bundle
interface ysyx_25020047_data_sram_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    // LSU side
    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    // Memory responder side
    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/ysyx_25020047_lat_cnt.sv
// rtl/ysyx_25020047_lat_cnt.sv - loadable down-counter with zero flag for access latency
module ysyx_25020047_lat_cnt
    import ysyx_25020047_data_sram_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority; decrement saturates at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ysyx_25020047_data_sram.sv
// rtl/ysyx_25020047_data_sram.sv - single-outstanding LSU data responder with programmable latency
module ysyx_25020047_data_sram
    import ysyx_25020047_data_sram_pkg::*;
#(
    parameter int          LATENCY   = 1,
    parameter logic [31:0] PMEM_BASE = PMEM_BASE_DEF,
    parameter logic [31:0] PMEM_SIZE = PMEM_SIZE_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    ysyx_25020047_data_sram_if.slave     bus,
    // Physical memory port: the access happens on the edge where ren/wen is high
    output logic                         pmem_ren_o,
    output logic                         pmem_wen_o,
    output logic [31:0]                  pmem_addr_o,
    output logic [31:0]                  pmem_wdata_o,
    output logic [3:0]                   pmem_wmask_o,
    input  logic [31:0]                  pmem_rdata_i
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    sram_state_e state_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        wen_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;

    logic        accept;
    logic        cnt_zero;
    logic        access_now;
    logic        acc_wen;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wmask;
    logic        acc_in_range;

    assign accept = (state_q == ST_IDLE) && bus.req_valid;

    ysyx_25020047_lat_cnt #(.W(CNT_W)) u_lat_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept && (LATENCY > 1)),
        .load_val_i (WAIT_LOAD),
        .dec_i      (state_q == ST_WAIT),
        .zero_o     (cnt_zero)
    );

    // Select the access source: live request on a latency-1 accept, latched request otherwise
    always_comb begin
        acc_wen    = wen_q;
        acc_addr   = addr_q;
        acc_wdata  = wdata_q;
        acc_wmask  = wmask_q;
        access_now = (state_q == ST_WAIT) && cnt_zero;
        if (state_q == ST_IDLE) begin
            acc_wen   = bus.req_wen;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_wmask = bus.req_wmask;
        end
        if (LATENCY == 1) begin
            access_now = accept;
        end
        acc_in_range = in_pmem(acc_addr, PMEM_BASE, PMEM_SIZE);
    end

    assign pmem_ren_o   = access_now && acc_in_range && !acc_wen;
    assign pmem_wen_o   = access_now && acc_in_range && acc_wen && (acc_wmask != 4'h0);
    assign pmem_addr_o  = word_align(acc_addr);
    assign pmem_wdata_o = acc_wdata;
    assign pmem_wmask_o = acc_wmask;

    // Request latch, access capture and handshake FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
        end else begin
            if (access_now) begin
                rdata_q <= (acc_in_range && !acc_wen) ? pmem_rdata_i : '0;
                err_q   <= !acc_in_range;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        wen_q       <= bus.req_wen;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        wmask_q     <= bus.req_wmask;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_zero) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_25020047_data_sram.sv
// tb/tb_ysyx_25020047_data_sram.sv - randomized self-checking bench for the data SRAM responder
module tb_ysyx_25020047_data_sram;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_clear = 1'b0;

    logic [2:0]  req_valid = '0;
    logic [2:0]  req_wen = '0;
    logic [2:0]  resp_ready = '0;
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_wmask [3];
    logic [2:0]  req_ready;
    logic [2:0]  resp_valid;
    logic [2:0]  resp_err;
    logic [31:0] resp_rdata [3];

    logic [2:0]  pm_ren;
    logic [2:0]  pm_wen;
    logic [31:0] pm_addr  [3];
    logic [31:0] pm_wdata [3];
    logic [3:0]  pm_wmask [3];
    logic [31:0] pm_rdata [3];

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    int          calls = 0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        ysyx_25020047_data_sram_if u_if ();
        assign u_if.req_valid  = req_valid[g];
        assign u_if.req_wen    = req_wen[g];
        assign u_if.req_addr   = req_addr[g];
        assign u_if.req_wdata  = req_wdata[g];
        assign u_if.req_wmask  = req_wmask[g];
        assign u_if.resp_ready = resp_ready[g];
        assign req_ready[g]    = u_if.req_ready;
        assign resp_valid[g]   = u_if.resp_valid;
        assign resp_rdata[g]   = u_if.resp_rdata;
        assign resp_err[g]     = u_if.resp_err;
        assign pm_rdata[g]     = mem[pm_addr[g][11:2]];

        ysyx_25020047_data_sram #(.LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4))) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .bus          (u_if),
            .pmem_ren_o   (pm_ren[g]),
            .pmem_wen_o   (pm_wen[g]),
            .pmem_addr_o  (pm_addr[g]),
            .pmem_wdata_o (pm_wdata[g]),
            .pmem_wmask_o (pm_wmask[g]),
            .pmem_rdata_i (pm_rdata[g])
        );
    end

    // Physical memory model: counts accesses and applies byte-masked writes
    always @(posedge clk) begin
        int k;
        k = 0;
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end
        for (int g = 0; g < 3; g++) begin
            if (pm_ren[g] || pm_wen[g]) k = k + 1;
            if (pm_wen[g]) begin
                for (int b = 0; b < 4; b++) begin
                    if (pm_wmask[g][b]) mem[pm_addr[g][11:2]][8*b +: 8] <= pm_wdata[g][8*b +: 8];
                end
            end
        end
        calls <= calls + k;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic in_window(input logic [31:0] a);
        longint unsigned x;
        x = {32'b0, a};
        return (x >= 64'h8000_0000) && (x < 64'h8000_0000 + 64'h0800_0000);
    endfunction

    // One full request/response exchange checked against the reference memory
    task automatic txn(input int d, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask,
                       input int hold, input logic early, output logic [31:0] rd);
        int          n;
        int          c0;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_calls;
        exp_err   = !in_window(addr);
        exp_calls = (!exp_err && (!wen || wmask != 4'h0)) ? 1 : 0;
        exp_rd    = (!exp_err && !wen) ? ref_mem[addr[11:2]] : 32'h0;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("req_ready_idle", 32'(req_ready[d]), 32'h1);
        c0 = calls;
        req_valid[d] = 1'b1; req_wen[d] = wen; req_addr[d] = addr;
        req_wdata[d] = wdata; req_wmask[d] = wmask;
        @(posedge clk); #1;
        req_valid[d] = 1'b0; req_wen[d] = 1'($urandom); req_addr[d] = $urandom;
        req_wdata[d] = $urandom; req_wmask[d] = 4'($urandom);
        if (early) resp_ready[d] = 1'b1;
        n = 1;
        while (!resp_valid[d] && n < 40) begin
            check("req_ready_busy", 32'(req_ready[d]), 32'h0);
            @(posedge clk); #1; n++;
        end
        check("latency", 32'(n), 32'(lat_of(d)));
        check("resp_err", 32'(resp_err[d]), 32'(exp_err));
        check("resp_rdata", resp_rdata[d], exp_rd);
        check("pmem_calls", 32'(calls - c0), 32'(exp_calls));
        rd = resp_rdata[d];
        if (!exp_err && wen) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) ref_mem[addr[11:2]][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        for (int i = 0; i < hold; i++) begin
            if (i == 1) req_valid[d] = 1'b1;
            @(posedge clk); #1;
            req_valid[d] = 1'b0;
            check("hold_valid", 32'(resp_valid[d]), 32'h1);
            check("hold_rdata", resp_rdata[d], exp_rd);
            check("hold_ready", 32'(req_ready[d]), 32'h0);
        end
        resp_ready[d] = 1'b1;
        @(posedge clk); #1;
        resp_ready[d] = 1'b0;
        check("post_valid", 32'(resp_valid[d]), 32'h0);
        check("post_ready", 32'(req_ready[d]), 32'h1);
        check("post_calls", 32'(calls - c0), 32'(exp_calls));
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int          c0;
        int          d;
        for (int g = 0; g < 3; g++) begin
            req_addr[g] = '0; req_wdata[g] = '0; req_wmask[g] = '0;
        end
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        mem_clear = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_clear = 1'b0;
        for (int g = 0; g < 3; g++) begin
            check("rst_req_ready", 32'(req_ready[g]), 32'h1);
            check("rst_resp_valid", 32'(resp_valid[g]), 32'h0);
            check("rst_rdata", resp_rdata[g], 32'h0);
            check("rst_err", 32'(resp_err[g]), 32'h0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency 1 full-word write then read
        txn(0, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, rd);
        txn(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 1'b0, rd);
        check("t1_read", rd, 32'hDEAD_BEEF);

        // Latency 3 byte-lane write merged into an existing word
        txn(1, 1'b1, 32'h8000_0000, 32'h1122_3344, 4'hF, 0, 1'b0, rd);
        txn(1, 1'b1, 32'h8000_0003, 32'hAB00_0000, 4'h8, 0, 1'b0, rd);
        txn(1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 1'b0, rd);
        check("t2_read", rd, 32'hAB22_3344);

        // Response held for several cycles with stray request pulses
        txn(1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 5, 1'b0, rd);
        check("t3_read", rd, 32'hAB22_3344);

        // Window boundaries
        txn(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, 1'b0, rd);
        check("t4_low_rd", rd, 32'h0);
        txn(0, 1'b0, 32'h8800_0000, 32'h0, 4'h0, 0, 1'b0, rd);
        check("t4_high_rd", rd, 32'h0);
        txn(2, 1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 4'hF, 0, 1'b0, rd);
        txn(0, 1'b1, 32'h87FF_FFFC, 32'h0BAD_CAFE, 4'hF, 0, 1'b0, rd);
        txn(1, 1'b0, 32'h87FF_FFFF, 32'h0, 4'h0, 0, 1'b0, rd);
        check("t4_top_rd", rd, 32'h0BAD_CAFE);

        // Reset while a write is still waiting: it must never reach memory
        a = 32'h8000_0040;
        txn(2, 1'b1, a, 32'h1111_1111, 4'hF, 0, 1'b0, rd);
        txn(2, 1'b0, a, 32'h0, 4'h0, 0, 1'b0, rd);
        c0 = calls;
        req_valid[2] = 1'b1; req_wen[2] = 1'b1; req_addr[2] = a;
        req_wdata[2] = 32'h2222_2222; req_wmask[2] = 4'hF;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_ready", 32'(req_ready[2]), 32'h1);
        check("t5_rst_valid", 32'(resp_valid[2]), 32'h0);
        check("t5_rst_rdata", resp_rdata[2], 32'h0);
        check("t5_rst_err", 32'(resp_err[2]), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_write", 32'(calls - c0), 32'h0);
        txn(2, 1'b0, a, 32'h0, 4'h0, 0, 1'b0, rd);
        check("t5_old_value", rd, 32'h1111_1111);

        // Empty byte mask: normal response, word untouched
        txn(0, 1'b1, 32'h8000_0010, 32'h55AA_55AA, 4'hF, 0, 1'b0, rd);
        txn(0, 1'b1, 32'h8000_0010, 32'h1234_5678, 4'h0, 0, 1'b0, rd);
        txn(1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, 1'b0, rd);
        check("t6_unchanged", rd, 32'h55AA_55AA);

        // Randomized traffic across all three latencies
        for (int t = 0; t < 80; t++) begin
            logic early;
            int   hold;
            d = int'($urandom_range(0, 2));
            if ($urandom_range(0, 99) < 85) begin
                a = 32'h8000_0000 + ($urandom_range(0, 31) << 2) + 32'($urandom_range(0, 3));
            end else begin
                a = $urandom;
            end
            early = ($urandom_range(0, 3) == 0);
            hold  = early ? 0 : int'($urandom_range(0, 3));
            txn(d, 1'($urandom), a, $urandom, 4'($urandom), hold, early, rd);
        end

        // Physical memory contents agree with the reference for the random region
        for (int i = 0; i < 32; i++) begin
            check("final_mem", mem[i], ref_mem[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
